// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads back a multiplexed, active-low 7-segment display.
// Registers the anode/segment lines, waits for a stable legal pattern and
// decodes it into a per-digit hex register file with valid flags.
// Optional build macro SEG_SCAN_TIMEOUT_EN adds parameter TIMEOUT and a
// per-digit age counter that drops digit_valid for digits not refreshed.
module seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned IDX_W         = 2
`ifdef SEG_SCAN_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT       = 1024
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic [6:0]              seg_n,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    new_digit,
    output logic [IDX_W-1:0]        new_idx,
    output logic                    bad_pattern
);

    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_DIGITS-1:0]   r_an_s;
    logic [NUM_DIGITS-1:0]   r_an_p;
    logic [6:0]              r_seg_s;
    logic [6:0]              r_seg_p;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_new_digit;
    logic                    r_bad;
    logic [IDX_W-1:0]        r_new_idx;

    logic [NUM_DIGITS-1:0]   w_low;
    logic [3:0]              w_nlow;
    logic                    w_legal;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_changed;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_settled;
    logic                    w_fire;
    logic                    w_dec_ok;
    logic [3:0]              w_dec_val;
    logic [NUM_DIGITS-1:0]   w_expire;

    // Input stage: current and previous registered samples; reset reads as blank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_s  <= '1;
            r_an_p  <= '1;
            r_seg_s <= '1;
            r_seg_p <= '1;
        end else begin
            r_an_s  <= an_n;
            r_an_p  <= r_an_s;
            r_seg_s <= seg_n;
            r_seg_p <= r_seg_s;
        end
    end

    assign w_low = ~r_an_s;

    // Select legality (exactly one anode low) and the index of the lit digit
    always_comb begin
        w_nlow = '0;
        w_idx  = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_nlow = w_nlow + {3'b000, w_low[i]};
            if (w_low[i]) begin
                w_idx = IDX_W'(i);
            end
        end
        w_legal = (w_nlow == 4'd1);
    end

    // Segment pattern to hex value; anything not an exact table entry is bad
    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_val = '0;
        case (r_seg_s)
            7'b0000001: w_dec_val = 4'h0;
            7'b1001111: w_dec_val = 4'h1;
            7'b0010010: w_dec_val = 4'h2;
            7'b0000110: w_dec_val = 4'h3;
            7'b1001100: w_dec_val = 4'h4;
            7'b0100100: w_dec_val = 4'h5;
            7'b0100000: w_dec_val = 4'h6;
            7'b0001111: w_dec_val = 4'h7;
            7'b0000000: w_dec_val = 4'h8;
            7'b0000100: w_dec_val = 4'h9;
            7'b0001000: w_dec_val = 4'hA;
            7'b1100000: w_dec_val = 4'hB;
            7'b0110001: w_dec_val = 4'hC;
            7'b1000010: w_dec_val = 4'hD;
            7'b0110000: w_dec_val = 4'hE;
            7'b0111000: w_dec_val = 4'hF;
            default:    w_dec_ok  = 1'b0;
        endcase
    end

    assign w_changed = (r_an_s != r_an_p) || (r_seg_s != r_seg_p);
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // The entry sample counts as the first stable sample, so each unchanged
    // comparison in SETTLE adds one; capture once STABLE_CYCLES samples agree.
    // With STABLE_CYCLES == 1 the entry sample alone is enough.
    always_comb begin
        w_settled = 1'b0;
        if (STABLE_CYCLES <= 1) begin
            w_settled = (r_state == ST_BLANK) || w_changed;
        end else begin
            w_settled = (r_state == ST_SETTLE) && !w_changed &&
                        (w_cnt_inc >= CNT_W'(STABLE_CYCLES - 1));
        end
        w_fire = w_legal && w_settled;
    end

`ifdef SEG_SCAN_TIMEOUT_EN
    localparam int unsigned AGE_W = $clog2(TIMEOUT + 1);

    logic [AGE_W-1:0] r_age [NUM_DIGITS];

    // Per-digit age since last capture, saturating at TIMEOUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (clr) begin
                    r_age[i] <= '0;
                end else if (w_fire && (w_idx == IDX_W'(i))) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != AGE_W'(TIMEOUT)) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    // A digit expires on the cycle its age reaches TIMEOUT, unless refreshed then
    always_comb begin
        w_expire = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_expire[i] = (r_age[i] == AGE_W'(TIMEOUT - 1)) &&
                          !(w_fire && (w_idx == IDX_W'(i)));
        end
    end
`else
    assign w_expire = '0;
`endif

    // Scan FSM with capture into the register file and registered pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_BLANK;
            r_cnt       <= '0;
            r_digits    <= '0;
            r_valid     <= '0;
            r_new_digit <= 1'b0;
            r_bad       <= 1'b0;
            r_new_idx   <= '0;
        end else begin
            r_new_digit <= 1'b0;
            r_bad       <= 1'b0;
            if (clr) begin
                r_state  <= ST_BLANK;
                r_cnt    <= '0;
                r_digits <= '0;
                r_valid  <= '0;
            end else begin
                case (r_state)
                    ST_BLANK: begin
                        if (w_legal) begin
                            r_state <= w_fire ? ST_LOCKED : ST_SETTLE;
                            r_cnt   <= '0;
                        end
                    end
                    ST_SETTLE: begin
                        if (!w_legal) begin
                            r_state <= ST_BLANK;
                            r_cnt   <= '0;
                        end else if (w_fire) begin
                            r_state <= ST_LOCKED;
                            r_cnt   <= w_cnt_inc;
                        end else if (w_changed) begin
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_changed) begin
                            r_cnt <= '0;
                            if (!w_legal) begin
                                r_state <= ST_BLANK;
                            end else begin
                                r_state <= w_fire ? ST_LOCKED : ST_SETTLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_BLANK;
                        r_cnt   <= '0;
                    end
                endcase

                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (w_expire[i]) begin
                        r_valid[i] <= 1'b0;
                    end
                end

                if (w_fire) begin
                    r_new_idx <= w_idx;
                    if (w_dec_ok) begin
                        r_new_digit <= 1'b1;
                    end else begin
                        r_bad <= 1'b1;
                    end
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        if (w_idx == IDX_W'(i)) begin
                            r_valid[i] <= w_dec_ok;
                            if (w_dec_ok) begin
                                r_digits[4*i +: 4] <= w_dec_val;
                            end
                        end
                    end
                end
            end
        end
    end

    assign digits      = r_digits;
    assign digit_valid = r_valid;
    assign new_digit   = r_new_digit;
    assign new_idx     = r_new_idx;
    assign bad_pattern = r_bad;

endmodule
